// File: rtl/hash_sequencer_pkg.sv
// Shared types, constants and lane arithmetic for the multi-block SHA-1 sequencer.
package hash_sequencer_pkg;

  localparam int BLOCK_W = 512;
  localparam int HASH_W  = 160;

  // FIPS 180-4 initial chaining value, H0 in the top word.
  localparam logic [HASH_W-1:0] SHA1_IV =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    ISSUE,
    COMPUTE,
    ACCUM,
    DONE
  } hseq_state_t;

  // Five independent mod-2^32 adds; carries never cross a 32-bit lane.
  function automatic logic [HASH_W-1:0] sha1_add160(input logic [HASH_W-1:0] a,
                                                    input logic [HASH_W-1:0] b);
    logic [HASH_W-1:0] s;
    s = '0;
    for (int i = 0; i < 5; i++) begin
      s[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
    end
    return s;
  endfunction

endpackage

// File: rtl/hash_sequencer_if.sv
// Block-memory read port and compression-core handshake seen by the sequencer.
interface hash_sequencer_if #(
  parameter int ADDR_W = 11
);
  import hash_sequencer_pkg::*;

  logic                bram_rd_en;
  logic [ADDR_W-1:0]   bram_addr;
  logic [BLOCK_W-1:0]  bram_rdata;
  logic                core_start;
  logic [BLOCK_W-1:0]  core_block;
  logic [HASH_W-1:0]   core_hin;
  logic                core_done;
  logic [HASH_W-1:0]   core_hout;

  // Sequencer side.
  modport master (
    output bram_rd_en, bram_addr, core_start, core_block, core_hin,
    input  bram_rdata, core_done, core_hout
  );

  // Memory / compression-core side.
  modport slave (
    input  bram_rd_en, bram_addr, core_start, core_block, core_hin,
    output bram_rdata, core_done, core_hout
  );

endinterface

// File: rtl/hash_sequencer.sv
// Multi-block SHA-1 sequencer: fetches pre-padded blocks, drives the compression
// core with the running chaining value and folds each result back in.
module hash_sequencer
  import hash_sequencer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_blocks,
  output logic                busy,
  output logic                done,
  output logic [HASH_W-1:0]   digest,
  hash_sequencer_if.master    bus
);

  hseq_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [HASH_W-1:0] chain;

  // The core always sees the live chaining value; it only changes in COMPUTE
  // on core_done or in IDLE on an accepted start, so it is stable while hashing.
  assign bus.core_hin = chain;

  // Sequencer FSM; strobes are registered on state entry so they are high
  // for exactly the cycle the FSM spends in FETCH / ISSUE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.bram_rd_en <= 1'b0;
      bus.bram_addr  <= '0;
      bus.core_start <= 1'b0;
      bus.core_block <= '0;
      digest         <= '0;
      chain          <= SHA1_IV;
      addr           <= '0;
      remaining      <= '0;
    end else begin
      done           <= 1'b0;
      bus.bram_rd_en <= 1'b0;
      bus.core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= num_blocks;
            chain     <= SHA1_IV;
            busy      <= 1'b1;
            if (num_blocks == '0) begin
              state <= DONE;
            end else begin
              state          <= FETCH;
              bus.bram_rd_en <= 1'b1;
              bus.bram_addr  <= base_addr;
            end
          end
        end
        FETCH: begin
          state <= WAIT_DATA;
        end
        WAIT_DATA: begin
          bus.core_block <= bus.bram_rdata;
          bus.core_start <= 1'b1;
          state          <= ISSUE;
        end
        ISSUE: begin
          state <= COMPUTE;
        end
        COMPUTE: begin
          if (bus.core_done) begin
            chain <= sha1_add160(chain, bus.core_hout);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          remaining <= remaining - CNT_W'(1);
          addr      <= addr + ADDR_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= DONE;
          end else begin
            state          <= FETCH;
            bus.bram_rd_en <= 1'b1;
            bus.bram_addr  <= addr + ADDR_W'(1);
          end
        end
        DONE: begin
          digest <= chain;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
